// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage
// Instruction-fetch stage: owns the program counter, drives a word-index
// address to a combinational instruction memory and captures the returned
// instruction with its PC and PC+4 into the IF/ID pipeline register.
// Handles stall, flush and branch/jump redirect with priority
//   rst > redirect_valid > flush > stall > advance.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   stall            hold PC and IF/ID
//   flush            replace the instruction entering IF/ID with a bubble
//   redirect_valid   load redirect_pc into the PC, bubble into IF/ID
//   redirect_pc      byte target of the redirect
//   imem_addr        word index to instruction memory (combinational from pc)
//   imem_inst        instruction memory read data (same cycle)
//   pc               current fetch PC (byte address)
//   ifid_*           IF/ID register: valid, inst, pc, pc4, misalign
//   fetch_cnt        number of valid instructions written into IF/ID
// ============================================================================
module if_fetch_stage #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0]   NOP_INST   = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_inst,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  ifid_valid,
    output logic [DATA_WIDTH-1:0] ifid_inst,
    output logic [ADDR_WIDTH-1:0] ifid_pc,
    output logic [ADDR_WIDTH-1:0] ifid_pc4,
    output logic                  ifid_misalign,
    output logic [31:0]           fetch_cnt
);

    localparam int unsigned CNT_WIDTH = 32;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pc4;
        logic                  misalign;
    } ifid_t;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    ifid_t                 ifid_q, ifid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  pc_misaligned;
    ifid_t                 bubble;
    ifid_t                 fetched;

    assign pc_plus4      = pc_q + ADDR_WIDTH'(4);
    assign pc_misaligned = |pc_q[1:0];

    // Misaligned fetches still read memory but deliver a NOP flagged for decode.
    assign bubble  = '{valid: 1'b0, inst: NOP_INST, pc: pc_q, pc4: pc_plus4, misalign: 1'b0};
    assign fetched = '{valid:    1'b1,
                       inst:     pc_misaligned ? NOP_INST : imem_inst,
                       pc:       pc_q,
                       pc4:      pc_plus4,
                       misalign: pc_misaligned};

    // Next-state selection in priority order.
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        cnt_d  = cnt_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            ifid_d = bubble;
        end else if (flush) begin
            ifid_d = bubble;
            if (!stall) begin
                pc_d = pc_plus4;
            end
        end else if (!stall) begin
            pc_d   = pc_plus4;
            ifid_d = fetched;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            ifid_q <= '{valid: 1'b0, inst: NOP_INST, pc: '0, pc4: '0, misalign: 1'b0};
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign imem_addr     = {2'b00, pc_q[ADDR_WIDTH-1:2]};
    assign pc            = pc_q;
    assign ifid_valid    = ifid_q.valid;
    assign ifid_inst     = ifid_q.inst;
    assign ifid_pc       = ifid_q.pc;
    assign ifid_pc4      = ifid_q.pc4;
    assign ifid_misalign = ifid_q.misalign;
    assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// tb_if_fetch_stage
// Scoreboard bench for if_fetch_stage. The driver applies one cycle of
// control inputs, advances a behavioural fetch model and pushes the expected
// post-edge state into a queue; a monitor pops and compares after each edge.
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_inst;
    logic [31:0] pc;
    logic        ifid_valid;
    logic [31:0] ifid_inst, ifid_pc, ifid_pc4;
    logic        ifid_misalign;
    logic [31:0] fetch_cnt;

    logic [31:0] salt = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] ipc;
        logic [31:0] pc4;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;   // reference model state

    always #5 clk = ~clk;

    // Instruction memory: word n holds (0x1000 + n) ^ salt.
    assign imem_inst = (32'h1000 + imem_addr) ^ salt;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_inst(imem_inst), .pc(pc),
        .ifid_valid(ifid_valid), .ifid_inst(ifid_inst), .ifid_pc(ifid_pc),
        .ifid_pc4(ifid_pc4), .ifid_misalign(ifid_misalign), .fetch_cnt(fetch_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] byte_pc);
        return (32'h1000 + (byte_pc >> 2)) ^ salt;
    endfunction

    task automatic model_reset();
        m.pc = 32'h0; m.valid = 1'b0; m.inst = NOP; m.ipc = 32'h0;
        m.pc4 = 32'h0; m.mis = 1'b0; m.cnt = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".pc"},        pc,                 32'h0);
        check({tag, ".imem_addr"}, imem_addr,          32'h0);
        check({tag, ".valid"},     32'(ifid_valid),    32'h0);
        check({tag, ".inst"},      ifid_inst,          NOP);
        check({tag, ".ifid_pc"},   ifid_pc,            32'h0);
        check({tag, ".pc4"},       ifid_pc4,           32'h0);
        check({tag, ".mis"},       32'(ifid_misalign), 32'h0);
        check({tag, ".cnt"},       fetch_cnt,          32'h0);
    endtask

    // One clock of stimulus: drive, predict, push, then wait past the edge.
    task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
        logic [31:0] cur;
        stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
        cur = m.pc;
        if (rv || fl) begin
            m.valid = 1'b0; m.inst = NOP; m.mis = 1'b0;
            m.ipc = cur; m.pc4 = cur + 32'd4;
            if (rv)       m.pc = rpc;
            else if (!st) m.pc = cur + 32'd4;
        end else if (!st) begin
            m.valid = 1'b1;
            m.mis   = (cur % 4) != 0;
            m.inst  = m.mis ? NOP : mem_word(cur);
            m.ipc   = cur;
            m.pc4   = cur + 32'd4;
            m.pc    = cur + 32'd4;
            m.cnt   = m.cnt + 32'd1;
        end
        sb.push_back(m);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            check("pc",        pc,                 e.pc);
            check("imem_addr", imem_addr,          e.pc >> 2);
            check("valid",     32'(ifid_valid),    32'(e.valid));
            check("inst",      ifid_inst,          e.inst);
            check("ifid_pc",   ifid_pc,            e.ipc);
            check("ifid_pc4",  ifid_pc4,           e.pc4);
            check("misalign",  32'(ifid_misalign), 32'(e.mis));
            check("fetch_cnt", fetch_cnt,          e.cnt);
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        model_reset();
        #13;
        check_reset_outputs("reset");
        @(posedge clk);
        #3 rst = 1'b0;

        // Sequential run from 0.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("seq.ifid_pc",   ifid_pc,   32'd12);
        check("seq.inst",      ifid_inst, 32'h1003);
        check("seq.fetch_cnt", fetch_cnt, 32'd4);

        // Stall holds everything.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("stall.pc",  pc,        32'd16);
        check("stall.cnt", fetch_cnt, 32'd4);

        // Redirect overrides stall and flush.
        step(1'b1, 1'b1, 1'b1, 32'h40);
        check("redir.pc",    pc,                32'h40);
        check("redir.valid", 32'(ifid_valid),   32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("redir.ifid_pc", ifid_pc,   32'h40);
        check("redir.inst",    ifid_inst, 32'h1010);

        // Misaligned redirect.
        step(1'b0, 1'b0, 1'b1, 32'h42);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("mis.flag", 32'(ifid_misalign), 32'h1);
        check("mis.inst", ifid_inst,          NOP);
        check("mis.pc",   pc,                 32'h46);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // PC wrap.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap.pc4", ifid_pc4, 32'h0);
        check("wrap.pc",  pc,       32'h0);

        // Randomized traffic with a different memory image.
        salt = $urandom;
        for (int i = 0; i < 400; i++) begin
            logic st, fl, rv;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 6) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 2) != 0) rpc[1:0] = 2'b00;
            if (i == 200) begin
                // Asynchronous reset while a stall and redirect are being requested.
                stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
                #1 rst = 1'b1;
                #1 check_reset_outputs("rst_mid");
                model_reset();
                #1 rst = 1'b0;
            end
            step(st, fl, rv, rpc);
        end

        // Mid-cycle reset takes effect without a clock edge.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        model_reset();
        #1 rst = 1'b0;

        check("sb.drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
